// File: rtl/filter_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : filter_tap_sequencer
// Brief    : Time-multiplexed FIR tap sequencer. Buffers samples in a circular
//            history, runs one shared signed MAC across the taps of the
//            selected filter, then shifts, saturates and emits one result.
// Revision : 1.0 - initial release
// ============================================================================
module filter_tap_sequencer #(
  parameter int SAMPLE_W   = 12,
  parameter int HIST_DEPTH = 16,
  parameter int ACC_W      = 24
) (
  input  logic                inClk,
  input  logic                inReset,
  input  logic [SAMPLE_W-1:0] inSample,
  input  logic                inSampleValid,
  input  logic [3:0]          inFilterType,
  output logic [SAMPLE_W-1:0] outSample,
  output logic                outSampleValid,
  output logic                outBusy,
  output logic                outOverrun
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  // One extra bit so the tap index can hold a full tap count of 16.
  localparam int IDX_W = PTR_W + 1;
  localparam int PROD_W = SAMPLE_W + 8;

  localparam logic [3:0] c_type_bypass = 4'b0000;
  localparam logic [3:0] c_type_lp     = 4'b0001;
  localparam logic [3:0] c_type_hp     = 4'b0010;
  localparam logic [3:0] c_type_ma     = 4'b0101;

  localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] c_sat_min = -c_sat_max - ACC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_n;
  logic                       w_accept;
  logic [SAMPLE_W-1:0]        r_hist [HIST_DEPTH];
  logic [PTR_W-1:0]           r_wptr;
  logic [PTR_W-1:0]           w_wptr_n;
  logic [PTR_W-1:0]           w_newest;
  logic [PTR_W:0]             w_rd_wide;
  logic [PTR_W-1:0]           w_rd;
  logic [3:0]                 r_type;
  logic [IDX_W-1:0]           r_taps;
  logic [2:0]                 r_shift;
  logic [IDX_W-1:0]           r_idx;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [7:0]          w_coef;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_shifted;
  logic [SAMPLE_W-1:0]        w_result;
  logic [SAMPLE_W-1:0]        w_tap;

  // Tap count for a filter code; unknown codes and bypass need no MAC cycles.
  function automatic logic [IDX_W-1:0] tap_count(input logic [3:0] t);
    case (t)
      c_type_lp, c_type_hp: tap_count = IDX_W'(8);
      c_type_ma:            tap_count = IDX_W'(16);
      default:              tap_count = '0;
    endcase
  endfunction

  // Normalising shift for a filter code.
  function automatic logic [2:0] shift_of(input logic [3:0] t);
    case (t)
      c_type_lp, c_type_hp: shift_of = 3'd6;
      c_type_ma:            shift_of = 3'd4;
      default:              shift_of = 3'd0;
    endcase
  endfunction

  // Binomial row 7; high pass negates the odd taps.
  function automatic logic signed [7:0] coef_of(input logic [3:0] t, input logic [IDX_W-1:0] i);
    logic signed [7:0] b;
    case (i[2:0])
      3'd0, 3'd7: b = 8'sd1;
      3'd1, 3'd6: b = 8'sd7;
      3'd2, 3'd5: b = 8'sd21;
      default:    b = 8'sd35;
    endcase
    case (t)
      c_type_lp: coef_of = b;
      c_type_hp: coef_of = i[0] ? -b : b;
      c_type_ma: coef_of = 8'sd1;
      default:   coef_of = 8'sd0;
    endcase
  endfunction

  // Pointer arithmetic written out so non-power-of-two depths also wrap correctly.
  always_comb begin
    w_wptr_n = (r_wptr == PTR_W'(HIST_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
    w_newest = (r_wptr == '0) ? PTR_W'(HIST_DEPTH - 1) : r_wptr - PTR_W'(1);
    if ({1'b0, w_newest} >= r_idx)
      w_rd_wide = {1'b0, w_newest} - r_idx;
    else
      w_rd_wide = {1'b0, w_newest} + IDX_W'(HIST_DEPTH) - r_idx;
    w_rd   = w_rd_wide[PTR_W-1:0];
    w_tap  = r_hist[w_rd];
    w_coef = coef_of(r_type, r_idx);
    w_prod = $signed(w_tap) * w_coef;
  end

  // Arithmetic shift floors toward -inf; clamp into the sample range.
  always_comb begin
    w_shifted = r_acc >>> r_shift;
    case (r_type)
      c_type_bypass: w_result = w_tap;
      c_type_lp, c_type_hp, c_type_ma: begin
        if (w_shifted > c_sat_max)
          w_result = c_sat_max[SAMPLE_W-1:0];
        else if (w_shifted < c_sat_min)
          w_result = c_sat_min[SAMPLE_W-1:0];
        else
          w_result = w_shifted[SAMPLE_W-1:0];
      end
      default: w_result = '0;
    endcase
  end

  // Next-state logic; a strobe is only accepted from IDLE.
  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (inSampleValid) begin
          w_accept  = 1'b1;
          w_state_n = (tap_count(inFilterType) == '0) ? ST_DONE : ST_MAC;
        end
      end
      ST_MAC: begin
        if (r_idx == r_taps - IDX_W'(1))
          w_state_n = ST_DONE;
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge inClk) begin
    if (inReset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_n;
  end

  // History write, MAC accumulation and registered outputs.
  always_ff @(posedge inClk) begin
    if (inReset) begin
      for (int i = 0; i < HIST_DEPTH; i++)
        r_hist[i] <= '0;
      r_wptr         <= '0;
      r_type         <= '0;
      r_taps         <= '0;
      r_shift        <= '0;
      r_idx          <= '0;
      r_acc          <= '0;
      outSample      <= '0;
      outSampleValid <= 1'b0;
      outOverrun     <= 1'b0;
    end else begin
      outSampleValid <= 1'b0;
      outOverrun     <= inSampleValid && (r_state != ST_IDLE);
      if (w_accept) begin
        r_hist[r_wptr] <= inSample;
        r_wptr         <= w_wptr_n;
        r_type         <= inFilterType;
        r_taps         <= tap_count(inFilterType);
        r_shift        <= shift_of(inFilterType);
        r_idx          <= '0;
        r_acc          <= '0;
      end
      if (r_state == ST_MAC) begin
        r_acc <= r_acc + {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
        r_idx <= r_idx + IDX_W'(1);
      end
      if (r_state == ST_DONE) begin
        outSample      <= w_result;
        outSampleValid <= 1'b1;
      end
    end
  end

  assign outBusy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_filter_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_tap_sequencer
// Brief    : Scoreboard bench for filter_tap_sequencer: stimulus pushes the
//            expected sample and latency, a monitor pops on outSampleValid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_tap_sequencer;

  logic        clk;
  logic        rst;
  logic [11:0] in_sample;
  logic        in_valid;
  logic [3:0]  in_type;
  logic [11:0] out_sample;
  logic        out_valid;
  logic        out_busy;
  logic        out_overrun;

  typedef struct {
    int val;
    int acc_edge;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ovr_cnt = 0;

  filter_tap_sequencer dut (
    .inClk          (clk),
    .inReset        (rst),
    .inSample       (in_sample),
    .inSampleValid  (in_valid),
    .inFilterType   (in_type),
    .outSample      (out_sample),
    .outSampleValid (out_valid),
    .outBusy        (out_busy),
    .outOverrun     (out_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pop one expectation per output strobe, count overrun pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_overrun) ovr_cnt++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", $signed(out_sample), -99999);
        end else begin
          e = sb.pop_front();
          chk("out_sample", $signed(out_sample), e.val);
          chk("latency", cyc - e.acc_edge, e.lat);
        end
      end
    end
  end

  // One-cycle strobe; the filter select is scrambled afterwards to prove it is latched.
  task automatic send(input logic [11:0] s, input logic [3:0] t, input bit push,
                      input int expv, input int lat);
    exp_t e;
    @(posedge clk); #1;
    in_sample = s;
    in_type   = t;
    in_valid  = 1'b1;
    if (push) begin
      e.val = expv; e.acc_edge = cyc + 1; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_type  = 4'hF;
    in_sample = 12'h000;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !out_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_busy", int'(out_busy), 0);
    chk("rst_out_overrun", int'(out_overrun), 0);
    rst = 1'b0;
  endtask

  initial begin
    automatic int lp_c[8] = '{1, 7, 21, 35, 35, 21, 7, 1};
    automatic int hp_exp[9] = '{-32, 255, -928, 2047, -2048, 2047, -2048, 2047, -2048};
    int ovr_before;
    rst = 1'b1; in_sample = '0; in_valid = 1'b0; in_type = '0;
    do_reset();

    // Reset aborts an in-flight low-pass computation.
    send(12'h055, 4'b0000, 1'b1, 12'h055, 1);
    wait_idle();
    send(12'd1000, 4'b0001, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    do_reset();
    repeat (20) @(posedge clk);
    send(12'h123, 4'b0000, 1'b1, 12'h123, 1);
    wait_idle();

    // Low-pass impulse response.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 12'd64 : 12'd0, 4'b0001, 1'b1, lp_c[i], 9);
      wait_idle();
    end

    // Moving-average step.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      send(12'd100, 4'b0101, 1'b1, (100 * k) / 16, 17);
      wait_idle();
    end

    // High-pass with alternating full-scale input, saturating once filled.
    do_reset();
    for (int j = 0; j < 9; j++) begin
      send((j % 2 == 0) ? 12'h801 : 12'h7FF, 4'b0010, 1'b1, hp_exp[j], 9);
      wait_idle();
    end

    // Overrun: a second strobe mid-MAC is dropped and flagged.
    do_reset();
    ovr_before = ovr_cnt;
    send(12'd160, 4'b0101, 1'b1, 10, 17);
    repeat (3) @(posedge clk);
    #1;
    in_sample = 12'd999; in_type = 4'b0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
    chk("overrun_pulses", ovr_cnt - ovr_before, 1);
    send(12'd16, 4'b0101, 1'b1, 11, 17);
    wait_idle();

    // Invalid code outputs 0 yet still records the sample.
    do_reset();
    send(12'd500, 4'b0111, 1'b1, 0, 1);
    wait_idle();
    send(12'd7, 4'b0000, 1'b1, 7, 1);
    wait_idle();
    send(12'd0, 4'b0001, 1'b1, 164, 9);
    wait_idle();

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("total_overruns", ovr_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
